// File: rtl/flappy_pkg.sv
// Shared types and default timing constants for the flappy button conditioning path.
package flappy_pkg;

  localparam int CLK_HZ          = 25000000;
  localparam int DEBOUNCE_CYCLES = 250000;
  localparam int REPEAT_CYCLES   = 2500000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flap_input_if.sv
// Button-side bundle: raw buttons in, conditioned strobes and levels out.
interface flap_input_if;
  logic up;
  logic start;
  logic flap_pulse;
  logic start_pulse;
  logic up_level;
  logic start_level;

  modport master (
    output up, start,
    input  flap_pulse, start_pulse, up_level, start_level
  );

  modport slave (
    input  up, start,
    output flap_pulse, start_pulse, up_level, start_level
  );
endinterface

// File: rtl/flap_input_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce/repeat FSM, registered pulse and level.
// Pulse and level rise DEBOUNCE_CYCLES+2 edges after the raw input is first sampled high.
module debounce_ch import flappy_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = flappy_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = flappy_pkg::REPEAT_CYCLES,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam bit RP_ON  = REPEAT_EN && (REPEAT_CYCLES > 0);
  localparam bit DB_ONE = (DEBOUNCE_CYCLES == 1);

  logic [1:0]    sync_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d;
  logic          pulse_q, level_q;
  logic          s;

  assign s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) begin
          // A single-sample debounce accepts the press without a wait state.
          if (DB_ONE) begin
            state_d = HELD;
            evt_d   = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          evt_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HELD: begin
        if (!s) begin
          if (DB_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = ONE;
          end
        end else if (RP_ON) begin
          if (cnt_q == RP_LAST) begin
            evt_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output stage sits one edge behind the FSM so pulse and level move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      pulse_q <= evt_q;
      level_q <= (state_q == HELD) || (state_q == RELEASE_WAIT);
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/flap_input.sv
// Player button conditioner: debounced flap (with auto-repeat) and start strobes plus levels.
// Both channels are independent; outputs registered inside each channel.
module flap_input import flappy_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = flappy_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = flappy_pkg::REPEAT_CYCLES
) (
  input logic        clk,
  input logic        rst,
  flap_input_if.slave bus
);

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b1)
  ) u_up (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.up),
    .pulse(bus.flap_pulse),
    .level(bus.up_level)
  );

  // Start must never auto-repeat, whatever the repeat period is set to.
  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b0)
  ) u_start (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.start),
    .pulse(bus.start_pulse),
    .level(bus.start_level)
  );

endmodule
